// File: rtl/pool_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pool_engine : streaming max/average pooling over square image windows.    |
// | Rev 1.0 : initial release                                                  |
// +--------------------------------------------------------------------------+
module pool_engine #(
  parameter int DATA_SZ = 16,
  parameter int ADDR_SZ = 16,
  parameter int MAX_WIN = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      mode,
  input  logic [DATA_SZ-1:0]        imgsNumber,
  input  logic [DATA_SZ-1:0]        imgSize,
  input  logic [DATA_SZ-1:0]        windowSize,
  input  logic [ADDR_SZ-1:0]        imgsAddress,
  input  logic [ADDR_SZ-1:0]        outAddress,
  output logic                      rdEnable,
  output logic [ADDR_SZ-1:0]        rdAddr,
  input  logic signed [DATA_SZ-1:0] rdData,
  input  logic                      rdValid,
  output logic                      writeEnable,
  output logic [ADDR_SZ-1:0]        writeAddr,
  output logic signed [DATA_SZ-1:0] writeOut,
  output logic                      done,
  output logic                      error
);

  localparam int c_ACC_SZ = DATA_SZ + 6;
  localparam int c_EXT_SZ = DATA_SZ + 2;

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_REQ   = 3'd1;
  localparam logic [2:0] c_WAIT  = 3'd2;
  localparam logic [2:0] c_WRITE = 3'd3;
  localparam logic [2:0] c_DONE  = 3'd4;

  localparam logic [DATA_SZ-1:0] c_ONE = DATA_SZ'(1);

  logic [2:0]                 r_state;
  logic                       r_mode;
  logic                       r_err;
  logic [DATA_SZ-1:0]         r_s;
  logic [DATA_SZ-1:0]         r_w;
  logic [DATA_SZ-1:0]         r_imgs;
  logic [2:0]                 r_shift;
  logic [ADDR_SZ-1:0]         r_ss;
  logic [ADDR_SZ-1:0]         r_ws;
  logic [ADDR_SZ-1:0]         r_chan_base;
  logic [ADDR_SZ-1:0]         r_row_start;
  logic [ADDR_SZ-1:0]         r_win_base;
  logic [ADDR_SZ-1:0]         r_rd_addr;
  logic [ADDR_SZ-1:0]         r_wr_addr;
  logic [DATA_SZ-1:0]         r_c;
  logic [DATA_SZ-1:0]         r_row0;
  logic [DATA_SZ-1:0]         r_col0;
  logic [DATA_SZ-1:0]         r_i;
  logic [DATA_SZ-1:0]         r_j;
  logic signed [c_ACC_SZ-1:0] r_acc;

  logic                       w_pow2;
  logic                       w_bad;
  logic [1:0]                 w_log2;
  logic                       w_first;
  logic                       w_last_i;
  logic                       w_last_j;
  logic                       w_more_col;
  logic                       w_more_row;
  logic                       w_last_c;
  logic signed [c_ACC_SZ-1:0] w_data_ext;
  logic [ADDR_SZ-1:0]         w_next_row_addr;

  assign w_pow2 = (windowSize & (windowSize - c_ONE)) == '0;
  assign w_bad  = (windowSize == '0) || (windowSize > imgSize) || (imgsNumber == '0) ||
                  (windowSize > DATA_SZ'(MAX_WIN)) || (mode && !w_pow2);

  always_comb begin
    w_log2 = 2'd0;
    case (windowSize)
      DATA_SZ'(2): w_log2 = 2'd1;
      DATA_SZ'(4): w_log2 = 2'd2;
      DATA_SZ'(8): w_log2 = 2'd3;
      default:     w_log2 = 2'd0;
    endcase
  end

  assign w_first    = (r_i == '0) && (r_j == '0);
  assign w_last_i   = (r_i == r_w - c_ONE);
  assign w_last_j   = (r_j == r_w - c_ONE);
  assign w_last_c   = (r_c == r_imgs - c_ONE);
  assign w_data_ext = c_ACC_SZ'(rdData);

  // A further window fits only if it ends inside the image; leftover edge pixels are skipped.
  assign w_more_col = (c_EXT_SZ'(r_col0) + c_EXT_SZ'(r_w) + c_EXT_SZ'(r_w)) <= c_EXT_SZ'(r_s);
  assign w_more_row = (c_EXT_SZ'(r_row0) + c_EXT_SZ'(r_w) + c_EXT_SZ'(r_w)) <= c_EXT_SZ'(r_s);

  assign w_next_row_addr = r_rd_addr + ADDR_SZ'(r_s) - ADDR_SZ'(r_w) + ADDR_SZ'(1);

  assign rdEnable    = (r_state == c_REQ);
  assign rdAddr      = r_rd_addr;
  assign writeEnable = (r_state == c_WRITE);
  assign writeAddr   = r_wr_addr;
  assign writeOut    = r_mode ? DATA_SZ'(r_acc >>> r_shift) : DATA_SZ'(r_acc);
  assign done        = (r_state == c_DONE);
  assign error       = r_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= c_IDLE;
      r_mode      <= 1'b0;
      r_err       <= 1'b0;
      r_s         <= '0;
      r_w         <= '0;
      r_imgs      <= '0;
      r_shift     <= '0;
      r_ss        <= '0;
      r_ws        <= '0;
      r_chan_base <= '0;
      r_row_start <= '0;
      r_win_base  <= '0;
      r_rd_addr   <= '0;
      r_wr_addr   <= '0;
      r_c         <= '0;
      r_row0      <= '0;
      r_col0      <= '0;
      r_i         <= '0;
      r_j         <= '0;
      r_acc       <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (enable) begin
            if (w_bad) begin
              r_err   <= 1'b1;
              r_state <= c_DONE;
            end else begin
              r_mode      <= mode;
              r_s         <= imgSize;
              r_w         <= windowSize;
              r_imgs      <= imgsNumber;
              r_shift     <= {w_log2, 1'b0};
              r_ss        <= ADDR_SZ'(imgSize) * ADDR_SZ'(imgSize);
              r_ws        <= ADDR_SZ'(windowSize) * ADDR_SZ'(imgSize);
              r_chan_base <= imgsAddress;
              r_row_start <= imgsAddress;
              r_win_base  <= imgsAddress;
              r_rd_addr   <= imgsAddress;
              r_wr_addr   <= outAddress;
              r_c         <= '0;
              r_row0      <= '0;
              r_col0      <= '0;
              r_i         <= '0;
              r_j         <= '0;
              r_acc       <= '0;
              r_state     <= c_REQ;
            end
          end
        end

        c_REQ: r_state <= c_WAIT;

        c_WAIT: begin
          if (rdValid) begin
            if (w_first)
              r_acc <= w_data_ext;
            else if (r_mode)
              r_acc <= r_acc + w_data_ext;
            else if (w_data_ext > r_acc)
              r_acc <= w_data_ext;

            if (w_last_j) begin
              r_j <= '0;
              if (w_last_i) begin
                r_i     <= '0;
                r_state <= c_WRITE;
              end else begin
                r_i       <= r_i + c_ONE;
                r_rd_addr <= w_next_row_addr;
                r_state   <= c_REQ;
              end
            end else begin
              r_j       <= r_j + c_ONE;
              r_rd_addr <= r_rd_addr + ADDR_SZ'(1);
              r_state   <= c_REQ;
            end
          end
        end

        c_WRITE: begin
          // Outputs are contiguous in c, r, k order, so a running pointer suffices.
          r_wr_addr <= r_wr_addr + ADDR_SZ'(1);
          if (w_more_col) begin
            r_col0     <= r_col0 + r_w;
            r_win_base <= r_win_base + ADDR_SZ'(r_w);
            r_rd_addr  <= r_win_base + ADDR_SZ'(r_w);
            r_state    <= c_REQ;
          end else if (w_more_row) begin
            r_col0      <= '0;
            r_row0      <= r_row0 + r_w;
            r_row_start <= r_row_start + r_ws;
            r_win_base  <= r_row_start + r_ws;
            r_rd_addr   <= r_row_start + r_ws;
            r_state     <= c_REQ;
          end else if (!w_last_c) begin
            r_c         <= r_c + c_ONE;
            r_col0      <= '0;
            r_row0      <= '0;
            r_chan_base <= r_chan_base + r_ss;
            r_row_start <= r_chan_base + r_ss;
            r_win_base  <= r_chan_base + r_ss;
            r_rd_addr   <= r_chan_base + r_ss;
            r_state     <= c_REQ;
          end else begin
            r_state <= c_DONE;
          end
        end

        c_DONE: begin
          if (!enable) begin
            r_err   <= 1'b0;
            r_state <= c_IDLE;
          end
        end

        default: r_state <= c_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pool_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pool_engine : directed self-checking bench for pool_engine.             |
// | Rev 1.0 : initial release                                                  |
// +--------------------------------------------------------------------------+
module tb_pool_engine;

  logic               clk = 1'b0;
  logic               reset;
  logic               enable;
  logic               mode;
  logic [15:0]        imgsNumber;
  logic [15:0]        imgSize;
  logic [15:0]        windowSize;
  logic [15:0]        imgsAddress;
  logic [15:0]        outAddress;
  logic               rdEnable;
  logic [15:0]        rdAddr;
  logic signed [15:0] rdData;
  logic               rdValid;
  logic               writeEnable;
  logic [15:0]        writeAddr;
  logic signed [15:0] writeOut;
  logic               done;
  logic               error;

  always #5 clk = ~clk;

  pool_engine #(.DATA_SZ(16), .ADDR_SZ(16), .MAX_WIN(8)) dut (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode),
    .imgsNumber(imgsNumber), .imgSize(imgSize), .windowSize(windowSize),
    .imgsAddress(imgsAddress), .outAddress(outAddress),
    .rdEnable(rdEnable), .rdAddr(rdAddr), .rdData(rdData), .rdValid(rdValid),
    .writeEnable(writeEnable), .writeAddr(writeAddr), .writeOut(writeOut),
    .done(done), .error(error)
  );

  int n_vec = 0;
  int n_bad = 0;
  int rd_delay = 0;
  int rd_count = 0;
  int bad_rd = 0;
  int cur_s = 4, cur_w = 2, cur_n = 1, cur_base = 0;
  int wa[$];
  int wd[$];
  int ex[$];
  logic signed [15:0] mem [0:255];

  task automatic check_vec(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Record writes and reads; flag any read outside the O*W region of its channel.
  always @(negedge clk) begin
    if (reset && writeEnable) begin
      wa.push_back(int'(writeAddr));
      wd.push_back(int'(writeOut));
    end
    if (reset && rdEnable) begin
      int off, lim, pix;
      rd_count++;
      off = int'(rdAddr) - cur_base;
      lim = (cur_s / cur_w) * cur_w;
      pix = off % (cur_s * cur_s);
      if (off < 0 || off >= cur_n * cur_s * cur_s || (pix / cur_s) >= lim || (pix % cur_s) >= lim)
        bad_rd++;
    end
  end

  // Memory responder: rdValid arrives rd_delay cycles after the minimum latency.
  initial begin
    logic [15:0] a;
    rdValid = 1'b0;
    rdData  = '0;
    forever begin
      @(negedge clk);
      if (reset && rdEnable) begin
        a = rdAddr;
        repeat (rd_delay + 1) @(negedge clk);
        rdValid = 1'b1;
        rdData  = mem[a[7:0]];
        @(posedge clk);
        #1 rdValid = 1'b0;
      end
    end
  end

  task automatic start_job(input bit m, input int s, input int w, input int n,
                           input int ib, input int ob);
    wa.delete();
    wd.delete();
    rd_count = 0;
    bad_rd   = 0;
    cur_s = s; cur_w = (w == 0) ? 1 : w; cur_n = n; cur_base = ib;
    mode = m; imgSize = 16'(s); windowSize = 16'(w); imgsNumber = 16'(n);
    imgsAddress = 16'(ib); outAddress = 16'(ob);
    enable = 1'b1;
  endtask

  task automatic wait_done(input string tag);
    for (int t = 0; t < 8000 && !done; t++) @(negedge clk);
    check_vec({tag, " done"}, int'(done), 1);
  endtask

  task automatic check_writes(input string tag, input int ob);
    check_vec({tag, " wcount"}, wa.size(), ex.size());
    for (int i = 0; i < ex.size() && i < wa.size(); i++) begin
      check_vec($sformatf("%s waddr%0d", tag, i), wa[i], ob + i);
      check_vec($sformatf("%s wdata%0d", tag, i), wd[i], ex[i]);
    end
  endtask

  task automatic end_job(input string tag);
    enable = 1'b0;
    @(negedge clk);
    check_vec({tag, " done clr"}, int'(done), 0);
    check_vec({tag, " err clr"}, int'(error), 0);
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; mode = 1'b0;
    imgsNumber = '0; imgSize = '0; windowSize = '0; imgsAddress = '0; outAddress = '0;
    for (int i = 0; i < 256; i++) mem[i] = 16'(i);
    mem[200] = -16'sd1; mem[201] = -16'sd2; mem[202] = -16'sd3; mem[203] = -16'sd4;

    repeat (2) @(negedge clk);
    check_vec("rst rdEnable", int'(rdEnable), 0);
    check_vec("rst writeEnable", int'(writeEnable), 0);
    check_vec("rst done", int'(done), 0);
    check_vec("rst error", int'(error), 0);
    check_vec("rst rdAddr", int'(rdAddr), 0);
    check_vec("rst writeAddr", int'(writeAddr), 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Max pooling, S=4 W=2
    start_job(1'b0, 4, 2, 1, 0, 100);
    wait_done("max");
    check_vec("max error", int'(error), 0);
    ex = '{5, 7, 13, 15};
    check_writes("max", 100);
    check_vec("max reads", rd_count, 16);
    end_job("max");

    // Average pooling, same image
    start_job(1'b1, 4, 2, 1, 0, 100);
    wait_done("avg");
    ex = '{2, 4, 10, 12};
    check_writes("avg", 100);
    end_job("avg");

    // Average of negative window floors toward -inf
    start_job(1'b1, 2, 2, 1, 200, 50);
    wait_done("avgneg");
    ex = '{-3};
    check_writes("avgneg", 50);
    end_job("avgneg");

    // S=5 W=2, two channels: edge row/column never read
    start_job(1'b0, 5, 2, 2, 0, 100);
    wait_done("s5");
    ex = '{6, 8, 16, 18, 31, 33, 41, 43};
    check_writes("s5", 100);
    check_vec("s5 reads", rd_count, 32);
    check_vec("s5 badrd", bad_rd, 0);
    end_job("s5");

    // Rejected configurations
    start_job(1'b1, 4, 3, 1, 0, 100);
    wait_done("w3avg");
    check_vec("w3avg error", int'(error), 1);
    repeat (3) @(negedge clk);
    check_vec("w3avg hold", int'(done), 1);
    check_vec("w3avg reads", rd_count, 0);
    check_vec("w3avg writes", wa.size(), 0);
    end_job("w3avg");

    start_job(1'b0, 4, 0, 1, 0, 100);
    wait_done("w0");
    check_vec("w0 error", int'(error), 1);
    check_vec("w0 reads", rd_count, 0);
    check_vec("w0 writes", wa.size(), 0);
    end_job("w0");

    // Slow memory
    rd_delay = 3;
    start_job(1'b0, 4, 2, 1, 0, 100);
    wait_done("slow");
    ex = '{5, 7, 13, 15};
    check_writes("slow", 100);
    check_vec("slow reads", rd_count, 16);
    end_job("slow");
    rd_delay = 0;

    // Reset mid-job after second write, then restart
    start_job(1'b0, 4, 2, 1, 0, 100);
    for (int t = 0; t < 2000 && wa.size() < 2; t++) @(posedge clk);
    check_vec("mid reached", wa.size(), 2);
    #1 reset = 1'b0;
    enable = 1'b0;
    #1;
    check_vec("mid rdEnable", int'(rdEnable), 0);
    check_vec("mid writeEnable", int'(writeEnable), 0);
    check_vec("mid done", int'(done), 0);
    check_vec("mid rdAddr", int'(rdAddr), 0);
    check_vec("mid writeAddr", int'(writeAddr), 0);
    check_vec("mid writeOut", int'(writeOut), 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    check_vec("mid idle writes", wa.size(), 2);
    check_vec("mid idle done", int'(done), 0);
    start_job(1'b0, 4, 2, 1, 0, 100);
    wait_done("restart");
    ex = '{5, 7, 13, 15};
    check_writes("restart", 100);
    end_job("restart");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
